// File: rtl/core_seq_ctrl_pkg.sv
// Shared constants, counter widths and state encoding for the systolic core sequencer.
package core_seq_ctrl_pkg;

    localparam int ROW      = 8;
    localparam int COL      = 8;
    localparam int LEN_KIJ  = 9;
    localparam int LEN_NIJ  = 36;
    localparam int ACT_BASE = 72;
    localparam int XA_W     = 7;
    localparam int PA_W     = 9;

    // Longest phase is A_EXEC: streaming plus pipeline drain.
    localparam int PH_W  = $clog2(LEN_NIJ + ROW + COL);
    localparam int KIJ_W = $clog2(LEN_KIJ);
    localparam int M_W   = $clog2(LEN_NIJ);

    typedef enum logic [2:0] {
        IDLE,
        W_LOAD,
        W_PUSH,
        A_LOAD,
        A_EXEC,
        P_MOVE,
        DONE
    } state_t;

endpackage

// File: rtl/core_seq_ctrl_cnt.sv
// Loadable up-counter with clear, enable and a terminal-count flag.
// Clear has priority over load, load over enable.
module core_seq_ctrl_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    input  logic         en,
    input  logic [W-1:0] tc_val,
    output logic [W-1:0] cnt,
    output logic         tc
);

    // Count register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (ld)
            cnt <= ld_val;
        else if (en)
            cnt <= cnt + 1'b1;
    end

    assign tc = (cnt == tc_val);

endmodule

// File: rtl/core_seq_ctrl.sv
// Sequencer for the weight-stationary systolic core.
// state  | meaning
// IDLE   | waiting for start
// W_LOAD | read ROW weight words of the current kij from xmem into L0
// W_PUSH | shift weights from L0 into the PE array (ROW reads + COL skew)
// A_LOAD | read LEN_NIJ activations from xmem into L0
// A_EXEC | stream activations through the array, then drain the pipeline
// P_MOVE | move LEN_NIJ psum rows from OFIFO into psum SRAM
// DONE   | all kernel positions finished; waits for start to drop
module core_seq_ctrl
    import core_seq_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [3:0]       kij,
    output logic             xmem_cen,
    output logic             xmem_wen,
    output logic [XA_W-1:0]  xmem_a,
    output logic             l0_wr,
    output logic             l0_rd,
    output logic             load,
    output logic             execute,
    input  logic             ofifo_valid,
    output logic             ofifo_rd,
    output logic             pmem_cen,
    output logic             pmem_wen,
    output logic [PA_W-1:0]  pmem_a
);

    state_t state, state_nxt;

    logic [PH_W-1:0]  phase, phase_tc_val;
    logic             phase_clr, phase_en, phase_tc;
    logic [KIJ_W-1:0] kij_cnt;
    logic             kij_clr, kij_en, kij_tc;
    logic [M_W-1:0]   m_cnt;
    logic             m_clr, m_tc;
    logic             pop_last;

    // Running weight address and psum base for the current kij.
    logic [XA_W-1:0]  w_ptr;
    logic [PA_W-1:0]  pmem_base;

    // The pop qualifies against the live ofifo_valid so an empty FIFO is never popped.
    assign ofifo_rd = (state == P_MOVE) && ofifo_valid;
    assign pop_last = ofifo_rd && m_tc;
    assign kij      = kij_cnt;

    core_seq_ctrl_cnt #(.W(PH_W)) u_phase_cnt (
        .clk(clk), .reset(reset), .clr(phase_clr), .ld(1'b0), .ld_val('0),
        .en(phase_en), .tc_val(phase_tc_val), .cnt(phase), .tc(phase_tc)
    );

    core_seq_ctrl_cnt #(.W(KIJ_W)) u_kij_cnt (
        .clk(clk), .reset(reset), .clr(kij_clr), .ld(1'b0), .ld_val('0),
        .en(kij_en), .tc_val(KIJ_W'(LEN_KIJ - 1)), .cnt(kij_cnt), .tc(kij_tc)
    );

    core_seq_ctrl_cnt #(.W(M_W)) u_m_cnt (
        .clk(clk), .reset(reset), .clr(m_clr), .ld(1'b0), .ld_val('0),
        .en(ofifo_rd), .tc_val(M_W'(LEN_NIJ - 1)), .cnt(m_cnt), .tc(m_tc)
    );

    // Next-state decode and counter controls.
    always_comb begin
        state_nxt    = state;
        phase_tc_val = PH_W'(ROW - 1);
        case (state)
            IDLE:   if (start) state_nxt = W_LOAD;
            W_LOAD: begin
                phase_tc_val = PH_W'(ROW - 1);
                if (phase_tc) state_nxt = W_PUSH;
            end
            W_PUSH: begin
                phase_tc_val = PH_W'(ROW + COL - 1);
                if (phase_tc) state_nxt = A_LOAD;
            end
            A_LOAD: begin
                phase_tc_val = PH_W'(LEN_NIJ - 1);
                if (phase_tc) state_nxt = A_EXEC;
            end
            A_EXEC: begin
                phase_tc_val = PH_W'(LEN_NIJ + ROW + COL - 1);
                if (phase_tc) state_nxt = P_MOVE;
            end
            P_MOVE: if (pop_last) state_nxt = kij_tc ? DONE : W_LOAD;
            DONE:   if (!start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        phase_clr = (state_nxt != state);
        phase_en  = (state == W_LOAD) || (state == W_PUSH) ||
                    (state == A_LOAD) || (state == A_EXEC);
        kij_clr   = (state == IDLE);
        kij_en    = pop_last && !kij_tc;
        m_clr     = (state != P_MOVE);
    end

    // State register and registered outputs, decoded from the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            xmem_cen  <= 1'b1;
            xmem_wen  <= 1'b1;
            xmem_a    <= '0;
            w_ptr     <= '0;
            l0_wr     <= 1'b0;
            l0_rd     <= 1'b0;
            load      <= 1'b0;
            execute   <= 1'b0;
            pmem_cen  <= 1'b1;
            pmem_wen  <= 1'b1;
            pmem_a    <= '0;
            pmem_base <= '0;
        end else begin
            state    <= state_nxt;
            busy     <= !((state_nxt == IDLE) || (state_nxt == DONE));
            done     <= (state_nxt == DONE);
            xmem_cen <= !((state_nxt == W_LOAD) || (state_nxt == A_LOAD));
            xmem_wen <= 1'b1;
            l0_wr    <= !xmem_cen;
            load     <= (state_nxt == W_PUSH);
            l0_rd    <= ((state_nxt == W_PUSH) &&
                         ((state != W_PUSH) || (phase < PH_W'(ROW - 1)))) ||
                        ((state_nxt == A_EXEC) &&
                         ((state != A_EXEC) || (phase < PH_W'(LEN_NIJ - 1))));
            execute  <= (state_nxt == A_EXEC) &&
                        ((state != A_EXEC) || (phase < PH_W'(LEN_NIJ - 1)));

            // Weights are contiguous across kij, so one running pointer covers the whole run.
            if (state_nxt == W_LOAD) begin
                xmem_a <= w_ptr;
                w_ptr  <= w_ptr + 1'b1;
            end else if (state_nxt == A_LOAD) begin
                xmem_a <= (state == A_LOAD) ? xmem_a + 1'b1 : XA_W'(ACT_BASE);
            end

            pmem_cen <= !ofifo_rd;
            pmem_wen <= !ofifo_rd;
            if (ofifo_rd)
                pmem_a <= pmem_base + PA_W'(m_cnt);

            if (state_nxt == IDLE) begin
                w_ptr     <= '0;
                pmem_base <= '0;
            end else if (pop_last) begin
                pmem_base <= pmem_base + PA_W'(LEN_NIJ);
            end
        end
    end

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed bench for core_seq_ctrl: full runs, stalled psum moves, start handling, mid-run reset.
module tb_core_seq_ctrl;
    import core_seq_ctrl_pkg::*;

    logic             clk, reset, start, ofifo_valid;
    logic             busy, done, xmem_cen, xmem_wen, l0_wr, l0_rd, load, execute;
    logic             ofifo_rd, pmem_cen, pmem_wen;
    logic [3:0]       kij;
    logic [XA_W-1:0]  xmem_a;
    logic [PA_W-1:0]  pmem_a;

    int n_chk = 0;
    int n_err = 0;

    int xq[$];
    int pq[$];
    int kchg[$];
    int cnt_l0wr, cnt_load, cnt_l0rd, cnt_exec, cnt_pop, cnt_busy, cnt_wen_lo;
    int l0wr_bad, pwr_bad, cyc_no, first_busy, done_cyc, prev_kij;
    logic prev_xrd;

    core_seq_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .kij(kij),
        .xmem_cen(xmem_cen), .xmem_wen(xmem_wen), .xmem_a(xmem_a),
        .l0_wr(l0_wr), .l0_rd(l0_rd), .load(load), .execute(execute),
        .ofifo_valid(ofifo_valid), .ofifo_rd(ofifo_rd),
        .pmem_cen(pmem_cen), .pmem_wen(pmem_wen), .pmem_a(pmem_a)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr_acc();
        xq.delete();
        pq.delete();
        kchg.delete();
        cnt_l0wr = 0; cnt_load = 0; cnt_l0rd = 0; cnt_exec = 0; cnt_pop = 0;
        cnt_busy = 0; cnt_wen_lo = 0; l0wr_bad = 0; pwr_bad = 0; cyc_no = 0;
        first_busy = -1; done_cyc = -1; prev_kij = 0; prev_xrd = 1'b0;
    endtask

    // One clock: drive inputs, sample the live pop, then sample registered outputs after the edge.
    task automatic cyc(input logic s, input logic v);
        logic pop, wr;
        start = s;
        ofifo_valid = v;
        #1;
        pop = ofifo_rd;
        if (pop) cnt_pop++;
        @(negedge clk);
        #1;
        cyc_no++;
        if (l0_wr !== prev_xrd) l0wr_bad++;
        prev_xrd = !xmem_cen;
        if (!xmem_cen) xq.push_back(int'(xmem_a));
        wr = !pmem_cen && !pmem_wen;
        if (wr !== pop) pwr_bad++;
        if (wr) pq.push_back(int'(pmem_a));
        if (!xmem_wen) cnt_wen_lo++;
        if (l0_wr) cnt_l0wr++;
        if (load) cnt_load++;
        if (l0_rd) cnt_l0rd++;
        if (execute) cnt_exec++;
        if (busy) cnt_busy++;
        if (busy && first_busy < 0) first_busy = cyc_no;
        if (done && done_cyc < 0) done_cyc = cyc_no;
        if (int'(kij) != prev_kij) begin
            kchg.push_back(cyc_no);
            prev_kij = int'(kij);
        end
    endtask

    task automatic chk_reset();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_kij", kij, 0);
        chk("rst_xmem_cen", xmem_cen, 1);
        chk("rst_xmem_wen", xmem_wen, 1);
        chk("rst_xmem_a", xmem_a, 0);
        chk("rst_l0_wr", l0_wr, 0);
        chk("rst_l0_rd", l0_rd, 0);
        chk("rst_load", load, 0);
        chk("rst_execute", execute, 0);
        chk("rst_ofifo_rd", ofifo_rd, 0);
        chk("rst_pmem_cen", pmem_cen, 1);
        chk("rst_pmem_wen", pmem_wen, 1);
        chk("rst_pmem_a", pmem_a, 0);
    endtask

    initial begin
        int exp_x, idx, nx, np;
        reset = 1'b0;
        start = 1'b1;
        ofifo_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk_reset();

        // Run A: start sampled on the first edge after reset release, ofifo_valid tied high.
        clr_acc();
        reset = 1'b1;
        cyc(1'b1, 1'b1);
        chk("rel_busy", busy, 1);
        chk("rel_xmem_cen", xmem_cen, 0);
        chk("rel_xmem_a", xmem_a, 0);
        chk("rel_kij", kij, 0);
        for (int i = 0; i < 3000 && !done; i++) cyc(1'b0, 1'b1);
        chk("a_done_reached", done, 1);
        chk("a_run_cycles", done_cyc - first_busy, 9 * 148);
        chk("a_busy_cycles", cnt_busy, 9 * 148);
        chk("a_kij_changes", kchg.size(), 8);
        if (kchg.size() == 8) begin
            chk("a_kij0_cycles", kchg[0] - first_busy, 148);
            chk("a_kij7_cycles", kchg[7] - kchg[6], 148);
        end
        chk("a_kij_final", kij, 8);
        chk("a_xmem_reads", xq.size(), 9 * 44);
        chk("a_pmem_writes", pq.size(), 324);
        chk("a_pops", cnt_pop, 324);
        chk("a_l0_wr_cnt", cnt_l0wr, 396);
        chk("a_l0_rd_cnt", cnt_l0rd, 396);
        chk("a_load_cnt", cnt_load, 144);
        chk("a_exec_cnt", cnt_exec, 324);
        chk("a_l0_wr_align", l0wr_bad, 0);
        chk("a_pmem_wr_align", pwr_bad, 0);
        chk("a_xmem_wen_low", cnt_wen_lo, 0);
        nx = (xq.size() < 396) ? xq.size() : 396;
        idx = 0;
        for (int k = 0; k < 9; k++) begin
            for (int i = 0; i < 44; i++) begin
                exp_x = (i < 8) ? (k * 8 + i) : (72 + i - 8);
                if (idx < nx) chk("a_xmem_a_seq", xq[idx], exp_x);
                idx++;
            end
        end
        np = (pq.size() < 324) ? pq.size() : 324;
        for (int i = 0; i < np; i++) chk("a_pmem_a_seq", pq[i], i);
        if (nx == 396) begin
            chk("a_k8_first_w", xq[352], 64);
            chk("a_k8_last_w", xq[359], 71);
        end
        if (np == 324) begin
            chk("a_k8_first_p", pq[288], 288);
            chk("a_k8_last_p", pq[323], 323);
        end
        cyc(1'b0, 1'b1);
        chk("a_done_drop", done, 0);
        chk("a_idle_busy", busy, 0);

        // Run B: start held high throughout, ofifo_valid toggling every cycle.
        clr_acc();
        for (int i = 0; i < 6000 && !done; i++) cyc(1'b1, 1'(i % 2));
        chk("b_done_reached", done, 1);
        chk("b_pops", cnt_pop, 324);
        chk("b_pmem_writes", pq.size(), 324);
        chk("b_pmem_wr_align", pwr_bad, 0);
        np = (pq.size() < 324) ? pq.size() : 324;
        for (int i = 0; i < np; i++) chk("b_pmem_a_seq", pq[i], i);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b1);
            chk("b_hold_done", done, 1);
            chk("b_hold_busy", busy, 0);
        end
        cyc(1'b0, 1'b1);
        chk("b_drop_done", done, 0);
        chk("b_drop_busy", busy, 0);

        // Run C: re-raise start, then reset in the middle of A_EXEC for kij 4.
        clr_acc();
        cyc(1'b1, 1'b1);
        chk("c_restart_busy", busy, 1);
        chk("c_restart_kij", kij, 0);
        chk("c_restart_xmem_a", xmem_a, 0);
        for (int i = 0; i < 2000 && !(kij == 4'd4 && execute); i++) cyc(1'b0, 1'b1);
        chk("c_reach_kij4_exec", int'(kij == 4'd4 && execute), 1);
        repeat (5) cyc(1'b0, 1'b1);
        chk("c_mid_exec", execute, 1);
        reset = 1'b0;
        #1;
        chk_reset();
        reset = 1'b1;
        clr_acc();
        cyc(1'b1, 1'b1);
        chk("c_post_rst_busy", busy, 1);
        chk("c_post_rst_kij", kij, 0);
        chk("c_post_rst_xmem_a", xmem_a, 0);
        cyc(1'b0, 1'b1);
        chk("c_post_rst_xmem_a1", xmem_a, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
